// File: rtl/conv_pkg.sv
// Shared definitions for the output-SRAM read path.
//   ADDR_W / DATA_W : default SRAM address and word widths
//   NCOLS_W         : width of the column-count configuration field
//   MASK_W          : one bit wider than a word so (1 << DATA_W) - 1 is representable
//   rd_state_t      : drain controller states
//   col_mask()      : column-count to row-word mask, out-of-range counts mean "all columns"
package conv_pkg;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NCOLS_W = 5;
  localparam int unsigned MASK_W  = DATA_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } rd_state_t;

  function automatic logic [DATA_W-1:0] col_mask(input logic [NCOLS_W-1:0] ncols);
    logic [NCOLS_W-1:0] n;
    logic [MASK_W-1:0]  m;
    if (ncols == '0 || ncols > NCOLS_W'(DATA_W)) begin
      n = NCOLS_W'(DATA_W);
    end else begin
      n = ncols;
    end
    m = (MASK_W'(1) << n) - MASK_W'(1);
    return m[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/output_sram_reader_if.sv
// Row stream from the output-SRAM reader to the host.
//   m_valid   : beat valid
//   m_ready   : consumer ready
//   m_data    : masked row word
//   m_row_idx : row index of the beat
//   m_last    : final row of the drain
interface output_sram_reader_if #(
  parameter int unsigned ADDR_W = conv_pkg::ADDR_W,
  parameter int unsigned DATA_W = conv_pkg::DATA_W
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_row_idx;
  logic              m_last;

  modport master (output m_valid, m_data, m_row_idx, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_row_idx, m_last, output m_ready);
endinterface

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO holding row beats (data, row index, last) between the SRAM read
// port and the output stream. Head entry drives the stream directly from flops.
//   clk, reset_b                         : clock, async active-low reset
//   push, push_data/row_idx/last         : write one beat
//   pop                                  : remove head beat
//   flush                                : drop all entries (wins over push/pop)
//   count                                : entries held, used as issue credit
//   head_data/row_idx/last               : head entry
module rd_skid_fifo #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_row_idx,
  input  logic              push_last,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_row_idx,
  output logic              head_last
);
  localparam int unsigned W = DATA_W + ADDR_W + 1;

  logic [W-1:0] head_q, tail_q, in_word;
  logic [1:0]   count_q;

  assign in_word = {push_data, push_row_idx, push_last};

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= in_word;
          else                 tail_q <= in_word;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= in_word;
          end else begin
            head_q <= tail_q;
            tail_q <= in_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = count_q;
  assign {head_data, head_row_idx, head_last} = head_q;

endmodule

// File: rtl/output_sram_reader.sv
// Drains the convolution output SRAM after a run and streams one masked word per
// output row to the host, with backpressure and no bubbles at full rate.
//   clk, reset_b          : clock, async active-low reset
//   start, dut_busy       : drain request, convolution engine busy flag
//   cfg_nrows, cfg_ncols  : rows to read, valid columns per row (sampled on start)
//   rd_sram_read_address  : SRAM read address (registered)
//   sram_rd_read_data     : SRAM data, one cycle after the address
//   m                     : row stream (master)
//   rd_busy, done, err    : drain active, completion pulse, reject/abort pulse
module output_sram_reader
  import conv_pkg::*;
#(
  parameter int unsigned       ADDR_W    = conv_pkg::ADDR_W,
  parameter int unsigned       DATA_W    = conv_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic               start,
  input  logic               dut_busy,
  input  logic [ADDR_W-1:0]  cfg_nrows,
  input  logic [NCOLS_W-1:0] cfg_ncols,
  output logic [ADDR_W-1:0]  rd_sram_read_address,
  input  logic [DATA_W-1:0]  sram_rd_read_data,
  output_sram_reader_if.master m,
  output logic               rd_busy,
  output logic               done,
  output logic               err
);
  rd_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d, nrows_q, nrows_d;
  logic [ADDR_W-1:0] issued_q, issued_d, beat_idx_q, beat_idx_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d, err_q, err_d, busy_q, busy_d;

  logic              issue, push, pop, abort;
  logic [1:0]        fifo_count;
  logic [2:0]        occupancy;

  // Entry to READ requires dut_busy low, so a high level here is a rising edge.
  assign abort = dut_busy && (state_q == StRead || state_q == StDrain);
  assign push  = inflight_q && !abort;
  assign pop   = m.m_valid && m.m_ready;
  // Count the word leaving this cycle so a full-rate stream never stalls issue.
  assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    nrows_d    = nrows_q;
    mask_d     = mask_q;
    issued_d   = issued_q;
    beat_idx_d = push ? beat_idx_q + ADDR_W'(1) : beat_idx_q;
    issue      = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (dut_busy) begin
            err_d = 1'b1;
          end else begin
            nrows_d    = cfg_nrows;
            mask_d     = col_mask(cfg_ncols);
            addr_d     = BASE_ADDR;
            issued_d   = '0;
            beat_idx_d = '0;
            state_d    = (cfg_nrows == '0) ? StDone : StRead;
          end
        end
      end
      StRead: begin
        if (abort) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          issue = (occupancy < 3'd2) && (issued_q != nrows_q);
          if (issue) begin
            addr_d   = addr_q + ADDR_W'(1);
            issued_d = issued_q + ADDR_W'(1);
          end
          if (issued_d == nrows_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (!inflight_q && fifo_count == 2'd1 && pop) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    inflight_d = issue;
    done_d     = (state_d == StDone);
    busy_d     = (state_d == StRead) || (state_d == StDrain);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= StIdle;
      addr_q     <= BASE_ADDR;
      nrows_q    <= '0;
      mask_q     <= '0;
      issued_q   <= '0;
      beat_idx_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      nrows_q    <= nrows_d;
      mask_q     <= mask_d;
      issued_q   <= issued_d;
      beat_idx_q <= beat_idx_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_row_idx;
  logic              head_last;

  rd_skid_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk          (clk),
    .reset_b      (reset_b),
    .push         (push),
    .push_data    (sram_rd_read_data & mask_q),
    .push_row_idx (beat_idx_q),
    .push_last    (beat_idx_q == nrows_q - ADDR_W'(1)),
    .pop          (pop),
    .flush        (abort),
    .count        (fifo_count),
    .head_data    (head_data),
    .head_row_idx (head_row_idx),
    .head_last    (head_last)
  );

  assign m.m_valid            = (fifo_count != 2'd0);
  assign m.m_data             = head_data;
  assign m.m_row_idx          = head_row_idx;
  assign m.m_last             = head_last;
  assign rd_sram_read_address = addr_q;
  assign rd_busy              = busy_q;
  assign done                 = done_q;
  assign err                  = err_q;

endmodule

// File: tb/tb_output_sram_reader.sv
module tb_output_sram_reader;

  logic        clk = 1'b0;
  logic        reset_b, start, start2, dut_busy;
  logic [11:0] cfg_nrows;
  logic [4:0]  cfg_ncols;
  logic [11:0] addr, addr2;
  logic [15:0] rdata, rdata2;
  logic        rd_busy, done, err, rd_busy2, done2, err2;
  logic [15:0] mem [4096];

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  output_sram_reader_if #(.ADDR_W(12), .DATA_W(16)) s_if ();
  output_sram_reader_if #(.ADDR_W(12), .DATA_W(16)) s2_if ();

  // Synchronous-read SRAM: data valid after the edge that samples the address.
  always @(posedge clk) begin
    rdata  <= mem[addr];
    rdata2 <= mem[addr2];
  end

  output_sram_reader #(.ADDR_W(12), .DATA_W(16), .BASE_ADDR(12'h000)) u_dut (
    .clk                  (clk),
    .reset_b              (reset_b),
    .start                (start),
    .dut_busy             (dut_busy),
    .cfg_nrows            (cfg_nrows),
    .cfg_ncols            (cfg_ncols),
    .rd_sram_read_address (addr),
    .sram_rd_read_data    (rdata),
    .m                    (s_if),
    .rd_busy              (rd_busy),
    .done                 (done),
    .err                  (err)
  );

  output_sram_reader #(.ADDR_W(12), .DATA_W(16), .BASE_ADDR(12'hFFE)) u_dut_wrap (
    .clk                  (clk),
    .reset_b              (reset_b),
    .start                (start2),
    .dut_busy             (dut_busy),
    .cfg_nrows            (cfg_nrows),
    .cfg_ncols            (cfg_ncols),
    .rd_sram_read_address (addr2),
    .sram_rd_read_data    (rdata2),
    .m                    (s2_if),
    .rd_busy              (rd_busy2),
    .done                 (done2),
    .err                  (err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [15:0] d, input logic [11:0] idx,
                      input logic last);
    check({tag, "_valid"}, s_if.m_valid, 1);
    check({tag, "_data"}, s_if.m_data, d);
    check({tag, "_idx"}, s_if.m_row_idx, idx);
    check({tag, "_last"}, s_if.m_last, last);
  endtask

  task automatic pulse_start(input logic [11:0] nrows, input logic [4:0] ncols);
    cfg_nrows = nrows;
    cfg_ncols = ncols;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  logic [15:0] bp_words [4];
  logic [15:0] held_data;
  logic [11:0] held_idx;
  logic        stalled, accepted, got_done;
  int          acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    reset_b = 1'b0; start = 1'b0; start2 = 1'b0; dut_busy = 1'b0;
    cfg_nrows = '0; cfg_ncols = '0;
    s_if.m_ready = 1'b0; s2_if.m_ready = 1'b1;
    #12;
    check("rst_addr", addr, 12'h000);
    check("rst_addr_wrap", addr2, 12'hFFE);
    check("rst_valid", s_if.m_valid, 0);
    check("rst_data", s_if.m_data, 0);
    check("rst_idx", s_if.m_row_idx, 0);
    check("rst_last", s_if.m_last, 0);
    check("rst_busy", rd_busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset_b = 1'b1;
    tick();

    // Basic drain
    mem[0] = 16'hFFFF; mem[1] = 16'hA5A5; mem[2] = 16'h0001;
    s_if.m_ready = 1'b1;
    pulse_start(12'd3, 5'd14);                    // E0
    check("b_addr_e0", addr, 12'h000);
    check("b_busy_e0", rd_busy, 1);
    check("b_valid_e0", s_if.m_valid, 0);
    tick();                                       // E1
    check("b_addr_e1", addr, 12'h001);
    check("b_valid_e1", s_if.m_valid, 0);
    tick(); beat("b_e2", 16'h3FFF, 12'd0, 1'b0);
    tick(); beat("b_e3", 16'h25A5, 12'd1, 1'b0);
    tick(); beat("b_e4", 16'h0001, 12'd2, 1'b1);
    check("b_done_e4", done, 0);
    check("b_busy_e4", rd_busy, 1);
    tick();                                       // E5
    check("b_done_e5", done, 1);
    check("b_valid_e5", s_if.m_valid, 0);
    check("b_busy_e5", rd_busy, 0);
    tick();
    check("b_done_e6", done, 0);

    // Backpressure with ready pattern 1,0,0,1
    bp_words[0] = 16'h1111; bp_words[1] = 16'h2222;
    bp_words[2] = 16'h3333; bp_words[3] = 16'h4444;
    for (int i = 0; i < 4; i++) mem[i] = bp_words[i];
    s_if.m_ready = 1'b0;
    pulse_start(12'd4, 5'd16);
    acc = 0; got_done = 1'b0; stalled = 1'b0; held_data = '0; held_idx = '0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      s_if.m_ready = (c % 4 == 0) || (c % 4 == 3);
      if (stalled) begin
        check("bp_hold_valid", s_if.m_valid, 1);
        check("bp_hold_data", s_if.m_data, held_data);
        check("bp_hold_idx", s_if.m_row_idx, held_idx);
      end
      accepted = s_if.m_valid && s_if.m_ready;
      if (accepted) begin
        check("bp_idx", s_if.m_row_idx, 12'(acc));
        check("bp_data", s_if.m_data, (acc < 4) ? bp_words[acc] : 16'hDEAD);
        check("bp_last", s_if.m_last, (acc == 3) ? 1 : 0);
      end
      check("bp_ahead", ((addr - 12'(acc)) <= 12'd2) ? 1 : 0, 1);
      stalled   = s_if.m_valid && !s_if.m_ready;
      held_data = s_if.m_data;
      held_idx  = s_if.m_row_idx;
      tick();
      if (accepted) acc++;
      if (done) got_done = 1'b1;
    end
    check("bp_beats", acc, 4);
    check("bp_done", got_done, 1);
    s_if.m_ready = 1'b1;
    tick();

    // Empty drain
    pulse_start(12'd0, 5'd16);
    check("e_done", done, 1);
    check("e_valid", s_if.m_valid, 0);
    check("e_busy", rd_busy, 0);
    tick();
    check("e_done_off", done, 0);
    check("e_valid_off", s_if.m_valid, 0);

    // Rejected start
    dut_busy = 1'b1;
    pulse_start(12'd3, 5'd16);
    dut_busy = 1'b0;
    check("r_err", err, 1);
    check("r_busy", rd_busy, 0);
    check("r_valid", s_if.m_valid, 0);
    tick();
    check("r_err_off", err, 0);
    check("r_busy_off", rd_busy, 0);

    // Abort after two accepted beats
    for (int i = 0; i < 5; i++) mem[i] = 16'h0101 * 16'(i + 1);
    pulse_start(12'd5, 5'd16);                    // E0
    tick(); tick(); beat("a_e2", 16'h0101, 12'd0, 1'b0);
    tick(); beat("a_e3", 16'h0202, 12'd1, 1'b0);
    tick(); beat("a_e4", 16'h0303, 12'd2, 1'b0);
    dut_busy = 1'b1;
    tick();
    check("a_valid", s_if.m_valid, 0);
    check("a_err", err, 1);
    check("a_done", done, 0);
    check("a_busy", rd_busy, 0);
    dut_busy = 1'b0;
    tick();
    check("a_err_off", err, 0);
    check("a_valid_off", s_if.m_valid, 0);
    mem[0] = 16'h1234; mem[1] = 16'h5678;
    pulse_start(12'd2, 5'd16);
    tick();
    check("a2_valid_e1", s_if.m_valid, 0);
    tick(); beat("a2_e2", 16'h1234, 12'd0, 1'b0);
    tick(); beat("a2_e3", 16'h5678, 12'd1, 1'b1);
    tick();
    check("a2_done", done, 1);
    tick();

    // Address wrap with ncols=0 clamped to full width
    mem[12'hFFE] = 16'h8001; mem[12'hFFF] = 16'h8002; mem[0] = 16'h8003; mem[1] = 16'h8004;
    cfg_nrows = 12'd4; cfg_ncols = 5'd0; start2 = 1'b1;
    tick(); start2 = 1'b0;
    check("w_addr_e0", addr2, 12'hFFE);
    tick(); check("w_addr_e1", addr2, 12'hFFF);
    tick(); check("w_addr_e2", addr2, 12'h000);
    check("w_data_e2", s2_if.m_data, 16'h8001);
    check("w_valid_e2", s2_if.m_valid, 1);
    tick(); check("w_addr_e3", addr2, 12'h001);
    check("w_data_e3", s2_if.m_data, 16'h8002);
    tick(); check("w_data_e4", s2_if.m_data, 16'h8003);
    tick(); check("w_data_e5", s2_if.m_data, 16'h8004);
    check("w_last_e5", s2_if.m_last, 1);
    check("w_idx_e5", s2_if.m_row_idx, 3);
    tick(); check("w_done", done2, 1);
    tick();

    // ncols above 16 clamped to full width
    mem[0] = 16'hF0F0;
    pulse_start(12'd1, 5'd20);
    tick(); tick(); beat("c20", 16'hF0F0, 12'd0, 1'b1);
    tick(); check("c20_done", done, 1);
    tick();

    // Reset in the middle of a drain
    mem[0] = 16'hAAAA; mem[1] = 16'hBBBB; mem[2] = 16'hCCCC;
    pulse_start(12'd3, 5'd16);
    tick(); tick();
    check("mr_valid_pre", s_if.m_valid, 1);
    reset_b = 1'b0;
    #1;
    check("mr_valid", s_if.m_valid, 0);
    check("mr_data", s_if.m_data, 0);
    check("mr_idx", s_if.m_row_idx, 0);
    check("mr_busy", rd_busy, 0);
    check("mr_addr", addr, 12'h000);
    #2;
    reset_b = 1'b1;
    tick();
    mem[0] = 16'hABCD;
    pulse_start(12'd1, 5'd8);
    tick(); tick(); beat("mr2", 16'h00CD, 12'd0, 1'b1);
    tick(); check("mr2_done", done, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/output_sram_reader.md
# output_sram_reader

Drains the convolution result SRAM after a run and streams the stored output rows to the host over a valid/ready interface. It is the read side of the output-SRAM write interface driven by the convolution datapath. That datapath writes one 16-bit word per output row, bit i holding column i, starting at the base address. This block waits for `dut_busy` low, reads `cfg_nrows` words sequentially, masks the unused column bits, and delivers one beat per row with backpressure and no bubbles.

## Interface
- `BASE_ADDR`, default 12'h000: first output-SRAM address read.
- `ADDR_W`, default 12: SRAM address width.
- `DATA_W`, default 16: SRAM word width, which is also the maximum number of columns.
- `clk`, input, 1: clock, rising edge.
- `reset_b`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: single-cycle request to begin a drain.
- `dut_busy`, input, 1: busy flag from the convolution engine.
- `cfg_nrows`, input, 12: number of output rows (words) to read. Sampled on accepted `start`.
- `cfg_ncols`, input, 5: valid columns per row, 1..16. Sampled on accepted `start`.
- `rd_sram_read_address`, output, 12: address to the output SRAM read port.
- `sram_rd_read_data`, input, 16: SRAM read data, valid one cycle after the address.
- `m_valid`, output, 1: stream beat valid.
- `m_ready`, input, 1: stream consumer ready.
- `m_data`, output, 16: masked row word.
- `m_row_idx`, output, 12: row index of the current beat, counting from 0.
- `m_last`, output, 1: current beat is row `cfg_nrows`-1.
- `rd_busy`, output, 1: drain in progress.
- `done`, output, 1: one-cycle pulse when the final beat is accepted, or when an empty drain completes.
- `err`, output, 1: one-cycle pulse when a `start` is rejected or a drain is aborted.

## Operation
- **States:** IDLE, READ, DRAIN, DONE.
- **Start acceptance:** in IDLE, `start` with `dut_busy`=0 is accepted.
  - Latches `nrows`, `ncols` and the mask.
  - Loads the address register with `BASE_ADDR` and clears the issue and beat counters.
  - Goes to READ, or to DONE if `cfg_nrows`=0.
- **Start rejection:** `start` with `dut_busy`=1 in IDLE pulses `err` and stays in IDLE. `start` in any other state is ignored with no `err`.
- **READ:** issues a read (address increments) in any cycle where outstanding reads plus buffered words is less than 2 and issued < `nrows`. Goes to DRAIN when issued == `nrows`.
- **DRAIN:** waits until every beat is accepted, then goes to DONE.
- **DONE:** pulses `done` for one cycle, then goes to IDLE.
- **Column mask:** (17'h1 << ncols) - 1, truncated to 16 bits. `cfg_ncols` of 0 or greater than 16 is treated as 16. `m_data` = SRAM word & mask.
- **Address arithmetic:** modulo 2^`ADDR_W`. BASE_ADDR + `nrows` past 4095 wraps to 0 and continues.
- **Beat transfer:** a beat transfers on `m_valid` & `m_ready`. `m_data`, `m_row_idx` and `m_last` hold stable while `m_valid`=1 and `m_ready`=0.
- **Abort:** `dut_busy` rising in READ or DRAIN aborts the drain.
  - Flushes the buffer and drops the read in flight.
  - `m_valid` goes to 0 next cycle.
  - Pulses `err` (no `done`) and returns to IDLE.
- **Reset values:** `rd_sram_read_address`=BASE_ADDR, `m_valid`=0, `m_data`=0, `m_row_idx`=0, `m_last`=0, `rd_busy`=0, `done`=0, `err`=0, state IDLE, buffer empty. A reset mid-drain discards everything immediately.

## Timing
- `start` accepted at edge E0:
  - `rd_sram_read_address`=BASE from E0.
  - The SRAM returns the word after E1; it is captured at E2.
  - `m_valid`=1 from E2, giving 2-cycle start-to-first-beat latency.
- **Throughput:** with `m_ready` held 1, one beat per cycle with no bubbles. The last beat appears at E(nrows+1), and `done` pulses the cycle after the last beat is accepted.
- **Backpressure:** with `m_ready` low, at most 2 words are held (1 in flight plus buffer). Issue resumes the cycle after the first acceptance.
- **`rd_busy`:** 1 from E0 until the cycle `done` or the abort `err` pulses.
- **Registered outputs:** all outputs come from flops; no combinational path from `m_ready` to `m_valid` or `m_data`.

## Structure
- **Shared package `conv_pkg`:** `ADDR_W`, `DATA_W`, the state enum `rd_state_t`, and the mask-width constant.
- **Sub-module `rd_skid_fifo`:** a 2-entry FIFO (16-bit data + 12-bit row index + last) with push/pop, count, and flush. It provides the credit count for issue control.

## Test plan
- **Basic drain:** nrows=3, ncols=14, SRAM words 16'hFFFF, 16'hA5A5, 16'h0001, `m_ready`=1 → beats 16'h3FFF, 16'h25A5, 16'h0001 at E2, E3, E4; `m_last` on beat 2; `done` at E5.
- **Backpressure:** nrows=4, `m_ready` toggling 1,0,0,1,... → no beat lost or duplicated; `m_row_idx` 0..3 in order; address never more than 2 ahead of the accepted count.
- **Empty and rejected starts:** nrows=0 → `done` 1 cycle after `start`, no `m_valid`. `start` with `dut_busy`=1 → `err` pulse, `rd_busy` stays 0.
- **Abort:** `dut_busy` raised after 2 of 5 beats → `m_valid`=0 next cycle, `err` pulse, IDLE; a new `start` then works cleanly.
- **Wrap and clamp:** BASE_ADDR=12'hFFE, nrows=4 → addresses FFE, FFF, 000, 001. ncols=0 and ncols=20 → mask 16'hFFFF.
- **Reset mid-drain:** assert `reset_b` during READ → all outputs at reset values asynchronously; next drain is correct.
